// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared constants and types for the memory-mapped I/O responder.
//   IO_ADDR_UART : UART data register (write = TX byte, read = RX byte)
//   IO_ADDR_CLK  : base of the 4-byte cycle counter / program-stop register
//   IO_WINDOW    : value of addr[17:16] that selects the I/O space
// ----------------------------------------------------------------------------
package io_pkg;

    localparam logic [17:0] IO_ADDR_UART = 18'h30000;
    localparam logic [17:0] IO_ADDR_CLK  = 18'h30004;
    localparam logic [1:0]  IO_WINDOW    = 2'b11;
    localparam int          CNT_W        = 32;

    typedef logic [7:0]       byte_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Little-endian byte k of a counter value.
    function automatic byte_t cnt_byte(input cnt_t v, input logic [1:0] k);
        return v[8*k +: 8];
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// ----------------------------------------------------------------------------
// io_tx_fifo
// Synchronous FIFO buffering CPU bytes toward the UART transmitter.
// A push into a full FIFO is still accepted when a pop happens on the same
// edge (the freed slot is the one being written).
// Ports:
//   clk_in, rst_n_in : clock, async active-low reset (clears storage too)
//   push_i, push_data_i : push request and byte
//   pop_i            : consume head byte (ignored when empty)
//   head_o, valid_o  : head byte, FIFO non-empty
//   count_o          : current occupancy
//   count_next_o     : occupancy after this edge
//   accept_o, drop_o : push taken / push refused because full
// ----------------------------------------------------------------------------
module io_tx_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o,
    output logic          accept_o,
    output logic          drop_o
);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop   = pop_i & (count_q != '0);
    assign accept_o = push_i & ((count_q != CW'(DEPTH)) | do_pop);
    assign drop_o   = push_i & ~accept_o;

    always_comb begin
        count_d = count_q;
        case ({accept_o, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (accept_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage is reset so the head byte reads 0 straight out of reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept_o) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign valid_o      = (count_q != '0);
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/io_responder.sv
// ----------------------------------------------------------------------------
// io_responder
// Device end of the CPU byte bus for the I/O window (addr[17:16] == 2'b11).
//   0x30000 W : UART TX byte (0x00 filtered out), queued in io_tx_fifo
//   0x30000 R : UART RX byte (0x00 if none), pulses rx_pop when consumed
//   0x30004 W : program stop; queues a 0x00 marker and arms stop_pending
//   0x30004..7 R : 32-bit cycle counter, little-endian
// Optional build macro IO_CYCLE_SNAPSHOT_EN: a read of 0x30004 latches the
// live counter so 0x30005..7 return bytes of the same dword.
// Ports:
//   clk_in, rst_n_in        : clock, async active-low reset
//   rdy_in                  : CPU ready; gates bus accesses and the counter
//   cpu_a, cpu_dout, cpu_wr : CPU address / write data / write strobe
//   cpu_din, io_sel_q       : registered read data and its I/O-select flag
//   io_buffer_full          : TX FIFO at/above high-water mark
//   tx_data, tx_valid, tx_ready : FIFO head toward the UART transmitter
//   rx_data, rx_valid, rx_pop   : UART receiver handshake
//   program_stop, tx_overflow   : sticky status
// ----------------------------------------------------------------------------
module io_responder
    import io_pkg::*;
#(
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_sel_q,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int            CW  = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] HWM = CW'(TX_DEPTH - FULL_MARGIN);

    logic        unused_addr_hi;
    logic [17:0] addr;
    logic        io_hit, rd_hit, wr_uart, wr_clk;
    logic        push, pop, push_accept, push_drop;
    byte_t       push_data, rd_data;
    logic        rd_pop;
    logic [CW-1:0] fifo_count, fifo_count_next;

    byte_t cpu_din_q, cpu_din_d;
    logic  io_sel_d;
    logic  rx_pop_q, rx_pop_d;
    cnt_t  cycle_q, cycle_d;
    logic  stop_pending_q, stop_pending_d;
    logic  program_stop_q, program_stop_d;
    logic  tx_overflow_q, tx_overflow_d;
    logic  io_buffer_full_q, io_buffer_full_d;

    assign unused_addr_hi = ^cpu_a[31:18];
    assign addr   = cpu_a[17:0];
    assign io_hit = rdy_in & (addr[17:16] == IO_WINDOW);
    assign rd_hit = io_hit & ~cpu_wr;

    // The stop marker is the only 0x00 that may enter the FIFO.
    assign wr_uart   = io_hit & cpu_wr & (addr == IO_ADDR_UART) & (cpu_dout != 8'h00);
    assign wr_clk    = io_hit & cpu_wr & (addr == IO_ADDR_CLK);
    assign push      = wr_uart | wr_clk;
    assign push_data = wr_clk ? 8'h00 : cpu_dout;
    assign pop       = tx_valid & tx_ready;

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_o       (tx_data),
        .valid_o      (tx_valid),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .accept_o     (push_accept),
        .drop_o       (push_drop)
    );

`ifdef IO_CYCLE_SNAPSHOT_EN
    cnt_t snap_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            snap_q <= '0;
        else if (rd_hit && addr == IO_ADDR_CLK)
            snap_q <= cycle_q;
    end

    // Byte 0 comes from the live counter on the same edge that fills snap_q.
    function automatic byte_t clk_rd_byte(input logic [1:0] k);
        return (k == 2'd0) ? cnt_byte(cycle_q, k) : cnt_byte(snap_q, k);
    endfunction
`else
    function automatic byte_t clk_rd_byte(input logic [1:0] k);
        return cnt_byte(cycle_q, k);
    endfunction
`endif

    always_comb begin
        rd_data = 8'h00;
        rd_pop  = 1'b0;
        if (addr == IO_ADDR_UART) begin
            rd_data = rx_valid ? rx_data : 8'h00;
            rd_pop  = rx_valid;
        end else if (addr[17:2] == IO_ADDR_CLK[17:2]) begin
            rd_data = clk_rd_byte(addr[1:0]);
        end
    end

    always_comb begin
        cpu_din_d        = cpu_din_q;
        cycle_d          = cycle_q;
        io_sel_d         = rd_hit;
        rx_pop_d         = rd_hit & rd_pop;
        stop_pending_d   = stop_pending_q | wr_clk;
        // Stop fires only once the marker has left and nothing new is landing.
        program_stop_d   = program_stop_q |
                           (stop_pending_q & (fifo_count == '0) & ~push_accept);
        tx_overflow_d    = tx_overflow_q | push_drop;
        io_buffer_full_d = (fifo_count_next >= HWM);
        if (rdy_in) begin
            cycle_d   = cycle_q + 1'b1;
            cpu_din_d = rd_hit ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cpu_din_q        <= '0;
            io_sel_q         <= 1'b0;
            rx_pop_q         <= 1'b0;
            cycle_q          <= '0;
            stop_pending_q   <= 1'b0;
            program_stop_q   <= 1'b0;
            tx_overflow_q    <= 1'b0;
            io_buffer_full_q <= 1'b0;
        end else begin
            cpu_din_q        <= cpu_din_d;
            io_sel_q         <= io_sel_d;
            rx_pop_q         <= rx_pop_d;
            cycle_q          <= cycle_d;
            stop_pending_q   <= stop_pending_d;
            program_stop_q   <= program_stop_d;
            tx_overflow_q    <= tx_overflow_d;
            io_buffer_full_q <= io_buffer_full_d;
        end
    end

    assign cpu_din        = cpu_din_q;
    assign rx_pop         = rx_pop_q;
    assign program_stop   = program_stop_q;
    assign tx_overflow    = tx_overflow_q;
    assign io_buffer_full = io_buffer_full_q;

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder: the device end of the CPU's byte-wide bus (address / data-out / write strobe / data-in, plus io_buffer_full).
- Decodes the I/O window (addr[17:16]==2'b11) and serves:
  - UART byte output at 0x30000, buffered in a TX FIFO toward the UART transmitter.
  - UART byte input at 0x30000.
  - The 4-byte cycle counter at 0x30004..0x30007.
  - The program-stop write at 0x30004.
- Sits beside the RAM at top level; its read data is muxed onto mem_din via io_sel_q.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of two, >=4.
- FULL_MARGIN, 2, free entries still remaining when io_buffer_full asserts; absorbs writes already issued by the CPU pipeline.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  CPU ready; bus accesses ignored and cycle counter frozen when low
- cpu_a  input  32  CPU address; only [17:0] decoded
- cpu_dout  input  8  write data from CPU
- cpu_wr  input  1  1 = write, 0 = read
- cpu_din  output  8  read data to CPU, registered, valid the cycle after the request
- io_sel_q  output  1  cpu_din holds I/O data this cycle (registered decode of last cycle's read)
- io_buffer_full  output  1  TX FIFO at or above high-water mark
- tx_data  output  8  byte to UART transmitter (FIFO head)
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  UART accepts head byte this cycle
- rx_data  input  8  received UART byte
- rx_valid  input  1  rx_data valid
- rx_pop  output  1  one-cycle pulse consuming rx_data
- program_stop  output  1  sticky; stop requested and stop byte drained
- tx_overflow  output  1  sticky; a write was dropped because the FIFO was full

Behaviour:
- Access decode: io_hit = rdy_in & (cpu_a[17:16]==2'b11). With rdy_in low there are no pushes, no pops and no register updates except the TX drain, which always runs.
- Reset (async, rst_n_in=0) clears:
  - cpu_din=0, io_sel_q=0, rx_pop=0, tx_valid=0, tx_data=0
  - program_stop=0, tx_overflow=0, io_buffer_full=0
  - FIFO pointers and count, cycle counter, stop_pending
  - Reset mid-operation discards FIFO contents.
- Write to 0x30000:
  - cpu_dout==0x00 is ignored.
  - Otherwise the byte is pushed.
- Write to 0x30004: pushes 0x00 (bypasses the zero filter) and sets stop_pending.
- Writes to other I/O addresses are ignored.
- FIFO push rules:
  - A push is accepted when count<TX_DEPTH, or when count==TX_DEPTH and a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and tx_overflow is set.
  - Pointers wrap modulo TX_DEPTH.
- FIFO pop: occurs when tx_valid & tx_ready. Simultaneous push and pop leaves count unchanged.
- io_buffer_full: registered, = (count_next >= TX_DEPTH-FULL_MARGIN).
- Read of 0x30000:
  - Next cycle, cpu_din = rx_valid ? rx_data : 0x00 (rx_data sampled at the request edge).
  - rx_pop pulses in the request cycle's registered output only if rx_valid was set.
- Read of 0x30004+k (k=0..3): next cycle, cpu_din = counter byte k, little-endian.
- Read of any other I/O address: cpu_din = 0x00.
- io_sel_q: set to 1 the cycle after any io_hit read; 0 otherwise.
- Cycle counter: 32-bit, +1 every clk_in with rdy_in=1, wraps 0xFFFFFFFF -> 0.
- program_stop: asserts the cycle after stop_pending=1 and count==0 with no push in flight; holds until reset. Later writes are still accepted.

Optional Feature:
- Macro: IO_CYCLE_SNAPSHOT_EN.
- Defined: a read of 0x30004 copies the live counter into a 32-bit snapshot register in the same edge and returns byte 0 of the live value. Reads of 0x30005..0x30007 return snapshot bytes, giving a coherent dword.
- Undefined: all four addresses return bytes of the live counter; no snapshot register.

Decomposition:
- Shared package io_pkg:
  - IO_ADDR_UART=18'h30000, IO_ADDR_CLK=18'h30004, IO_WINDOW=2'b11
  - byte typedef, counter width constant
- One sub-module io_tx_fifo (parameterised synchronous FIFO exposing count).
- Decode, counter and stop logic stay in io_responder.

Test Plan:
- Reset then write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only; program_stop=0.
- TX_DEPTH=8, FULL_MARGIN=2, tx_ready=0, 9 nonzero writes -> io_buffer_full rises after the 6th push; 9th write dropped; tx_overflow=1; count=8.
- rx_valid=1, rx_data=0x5A, read 0x30000 -> next cycle cpu_din=0x5A, io_sel_q=1, rx_pop one pulse. Repeat with rx_valid=0 -> cpu_din=0x00, no pulse.
- Run 0x1234 cycles with rdy_in=1 (plus 10 with rdy_in=0), read 0x30004..0x30007 -> bytes 0x34, 0x12, 0x00, 0x00 (± read-offset cycles under snapshot off). With IO_CYCLE_SNAPSHOT_EN the dword is exact at the first read.
- Queue 3 bytes, write 0x30004, tx_ready=1 -> 0x00 emitted last; program_stop asserts one cycle after FIFO empties and stays high.
- Assert rst_n_in low mid-drain with 5 bytes queued -> all outputs zero immediately (async); after release tx_valid=0 and the counter restarts from 0.
